// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, in-order imem requests, response FIFO feeding decode.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstN,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemValid,
    input  logic [31:0] imemRdata,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic [31:0] inst,
    output logic [31:0] instPc,
    output logic        instValid,
    input  logic        instReady
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW:0]   DEPTH_L = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   fifo_word [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];

    logic          fifo_empty;
    logic [CW:0]   inflight;
    logic          grant;
    logic          resp_fire;
    logic          resp_keep;
    logic          push;
    logic          pop;

    always_comb begin
        fifo_empty = (fifo_count == '0);
        // Buffered words plus outstanding requests never exceed the FIFO depth,
        // so every response is guaranteed a slot.
        inflight   = {1'b0, fifo_count} + {1'b0, outstanding};
        imemReq    = rstN && !redirect && (inflight < DEPTH_L);
        imemAddr   = fetch_pc;
        grant      = imemReq && imemGnt;
        resp_fire  = imemValid && (outstanding != '0);
        resp_keep  = resp_fire && (drop_count == '0) && !redirect;
        pop        = !fifo_empty && instReady;
    end

`ifdef FETCH_BYPASS_EN
    logic bypass_hit;

    always_comb begin
        bypass_hit = fifo_empty && resp_keep;
        push       = resp_keep && !(bypass_hit && instReady);
        instValid  = !fifo_empty || bypass_hit;
        inst       = bypass_hit ? imemRdata : fifo_word[rd_ptr];
        instPc     = bypass_hit ? resp_pc   : fifo_pc[rd_ptr];
    end
`else
    always_comb begin
        push      = resp_keep;
        instValid = !fifo_empty;
        inst      = fifo_word[rd_ptr];
        instPc    = fifo_pc[rd_ptr];
    end
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_count  <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_word[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (redirect) begin
            // No grant is possible here; every request still in flight after
            // this cycle's response belongs to the abandoned path.
            fetch_pc    <= {redirectPc[31:2], 2'b00};
            resp_pc     <= {redirectPc[31:2], 2'b00};
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= resp_fire ? outstanding - CNT_ONE : outstanding;
            drop_count  <= resp_fire ? outstanding - CNT_ONE : outstanding;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            case ({grant, resp_fire})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase
            if (resp_fire && (drop_count != '0)) begin
                drop_count <= drop_count - CNT_ONE;
            end
            if (resp_keep) begin
                resp_pc <= resp_pc + 32'd4;
            end
            if (push) begin
                fifo_word[wr_ptr] <= imemRdata;
                fifo_pc[wr_ptr]   <= resp_pc;
                wr_ptr            <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (FIFO_DEPTH=2, RESET_PC=0): reset, streaming,
// backpressure, redirect drop, alignment/wrap, collision and bypass latency.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redir;
    logic [31:0] redir_pc;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk        (clk),
        .rstN       (rst_n),
        .imemReq    (imem_req),
        .imemAddr   (imem_addr),
        .imemGnt    (imem_gnt),
        .imemValid  (imem_valid),
        .imemRdata  (imem_rdata),
        .redirect   (redir),
        .redirectPc (redir_pc),
        .inst       (inst),
        .instPc     (inst_pc),
        .instValid  (inst_valid),
        .instReady  (inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return 32'hA500_0000 ^ addr;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then settle before checking.
    task automatic step(input logic gnt, input logic vld, input logic [31:0] rdata,
                        input logic rdy, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        imem_gnt   = gnt;
        imem_valid = vld;
        imem_rdata = rdata;
        inst_ready = rdy;
        redir      = rd;
        redir_pc   = rpc;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; redir = 1'b0; redir_pc = '0;
        #1;
        chk("rst_req",   {31'b0, imem_req},   32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst",  inst,                32'd0);
        chk("rst_pc",    inst_pc,             32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming, latency 1
        step(1, 0, 0, 0, 0, 0);
        chk("c1_req",  {31'b0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        step(1, 1, word_at(32'h0), 0, 0, 0);
        chk("c2_req",  {31'b0, imem_req}, 32'd1);
        chk("c2_addr", imem_addr, 32'h4);
        step(1, 1, word_at(32'h4), 1, 0, 0);
        chk("c3_req",   {31'b0, imem_req},   32'd0);
        chk("c3_valid", {31'b0, inst_valid}, 32'd1);
        chk("c3_pc",    inst_pc, 32'h0);
        chk("c3_inst",  inst,    32'hA500_0000);
        step(1, 0, 0, 1, 0, 0);
        chk("c4_req",  {31'b0, imem_req}, 32'd1);
        chk("c4_addr", imem_addr, 32'h8);
        chk("c4_pc",   inst_pc, 32'h4);
        chk("c4_inst", inst,    32'hA500_0004);
        step(0, 1, word_at(32'h8), 0, 0, 0);
        chk("c5_addr", imem_addr, 32'hC);
        step(0, 0, 0, 1, 0, 0);
        chk("c6_valid", {31'b0, inst_valid}, 32'd1);
        chk("c6_pc",    inst_pc, 32'h8);
        chk("c6_inst",  inst,    32'hA500_0008);

        // Backpressure: only two requests may be in flight/buffered
        step(1, 0, 0, 0, 0, 0);
        chk("b1_valid", {31'b0, inst_valid}, 32'd0);
        chk("b1_addr",  imem_addr, 32'hC);
        step(1, 1, word_at(32'hC), 0, 0, 0);
        chk("b2_addr", imem_addr, 32'h10);
        step(1, 1, word_at(32'h10), 0, 0, 0);
        chk("b3_req", {31'b0, imem_req}, 32'd0);
        step(1, 0, 0, 0, 0, 0);
        chk("b4_req",   {31'b0, imem_req}, 32'd0);
        chk("b4_pc",    inst_pc, 32'hC);
        step(0, 0, 0, 1, 0, 0);
        chk("b5_req",  {31'b0, imem_req}, 32'd0);
        chk("b5_inst", inst, 32'hA500_000C);
        step(1, 0, 0, 1, 0, 0);
        chk("b6_pc",   inst_pc, 32'h10);
        chk("b6_inst", inst,    32'hA500_0010);
        chk("b6_req",  {31'b0, imem_req}, 32'd1);
        chk("b6_addr", imem_addr, 32'h14);
        step(1, 1, word_at(32'h14), 0, 0, 0);
        chk("b7_addr", imem_addr, 32'h18);
        step(0, 0, 0, 1, 0, 0);
        chk("b8_pc", inst_pc, 32'h14);
        step(1, 0, 0, 0, 0, 0);
        chk("b9_addr", imem_addr, 32'h1C);

        // Redirect with two outstanding (0x18, 0x1C)
        step(1, 0, 0, 0, 1, 32'h200);
        chk("r1_req", {31'b0, imem_req}, 32'd0);
        step(0, 1, word_at(32'h18), 0, 0, 0);
        chk("r2_addr", imem_addr, 32'h200);
        chk("r2_req",  {31'b0, imem_req}, 32'd0);
        step(1, 1, word_at(32'h1C), 0, 0, 0);
        chk("r3_valid", {31'b0, inst_valid}, 32'd0);
        chk("r3_addr",  imem_addr, 32'h200);
        step(0, 1, word_at(32'h200), 0, 0, 0);
        chk("r4_addr", imem_addr, 32'h204);
        step(0, 0, 0, 1, 0, 0);
        chk("r5_valid", {31'b0, inst_valid}, 32'd1);
        chk("r5_pc",    inst_pc, 32'h200);
        chk("r5_inst",  inst,    32'hA500_0200);

        // Misaligned redirect and address wrap
        step(0, 0, 0, 0, 1, 32'h103);
        step(0, 0, 0, 0, 0, 0);
        chk("r7_addr",  imem_addr, 32'h100);
        chk("r7_valid", {31'b0, inst_valid}, 32'd0);
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0, 0);
        chk("r9_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 1, word_at(32'hFFFF_FFFC), 0, 0, 0);
        chk("r10_addr", imem_addr, 32'h0);
        step(1, 0, 0, 0, 0, 0);
        chk("r11_pc",   inst_pc, 32'hFFFF_FFFC);
        chk("r11_inst", inst,    32'h5AFF_FFFC);

        // Collision: redirect + response + pop in the same cycle
        step(0, 1, word_at(32'h0), 1, 1, 32'h300);
        chk("r12_req",   {31'b0, imem_req},   32'd0);
        chk("r12_valid", {31'b0, inst_valid}, 32'd1);
        step(1, 0, 0, 1, 0, 0);
        chk("r13_valid", {31'b0, inst_valid}, 32'd0);
        chk("r13_addr",  imem_addr, 32'h300);
        step(0, 1, word_at(32'h300), 0, 0, 0);
`ifdef FETCH_BYPASS_EN
        chk("r14_valid", {31'b0, inst_valid}, 32'd1);
        chk("r14_inst",  inst, 32'hA500_0300);
`else
        chk("r14_valid", {31'b0, inst_valid}, 32'd0);
`endif
        step(1, 0, 0, 1, 0, 0);
        chk("r15_valid", {31'b0, inst_valid}, 32'd1);
        chk("r15_pc",    inst_pc, 32'h300);
        chk("r15_inst",  inst,    32'hA500_0300);
        chk("r15_addr",  imem_addr, 32'h304);

        // Response latency to decode with an empty FIFO and decode ready
        step(0, 1, 32'h0050_0093, 1, 0, 0);
`ifdef FETCH_BYPASS_EN
        chk("r16_valid", {31'b0, inst_valid}, 32'd1);
        chk("r16_inst",  inst,    32'h0050_0093);
        chk("r16_pc",    inst_pc, 32'h304);
        step(0, 0, 0, 1, 0, 0);
        chk("r17_valid", {31'b0, inst_valid}, 32'd0);
`else
        chk("r16_valid", {31'b0, inst_valid}, 32'd0);
        step(0, 0, 0, 1, 0, 0);
        chk("r17_valid", {31'b0, inst_valid}, 32'd1);
        chk("r17_inst",  inst,    32'h0050_0093);
        chk("r17_pc",    inst_pc, 32'h304);
`endif

        // Spurious response with nothing outstanding is ignored
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("r18_valid", {31'b0, inst_valid}, 32'd0);
        step(1, 0, 0, 0, 0, 0);
        chk("r19_valid", {31'b0, inst_valid}, 32'd0);
        chk("r19_addr",  imem_addr, 32'h308);

        // Reset mid-operation
        @(negedge clk);
        imem_gnt = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mr_req",   {31'b0, imem_req},   32'd0);
        chk("mr_valid", {31'b0, inst_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_addr", imem_addr, 32'h0);
        chk("mr_req1", {31'b0, imem_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
